// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Shared opcodes, FSM state encoding and datapath select encodings
//            for the multicycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_RTEXEC   = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BEQEXEC  = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_JEXEC    = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REGB     = 2'd0,
        SRCB_FOUR     = 2'd1,
        SRCB_IMM      = 2'd2,
        SRCB_IMM_SHL2 = 2'd3
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2
    } pc_src_t;

    typedef struct packed {
        logic is_rtype;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_addi;
        logic is_j;
        logic is_illegal;
    } op_class_t;

    // State-only (Moore) strobes; the FETCH handshake terms are added at the top.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       pc_write;
        logic       branch;
        pc_src_t    pc_src;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    function automatic ctrl_t ctrl_for_state(input state_t s, input logic from_rtype);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            ST_DECODE:   c.alu_src_b = SRCB_IMM_SHL2;
            ST_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            ST_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_RTEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = from_rtype;
            end
            ST_BEQEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.branch    = 1'b1;
                c.pc_src    = PCSRC_ALUOUT;
            end
            ST_ADDIEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_JEXEC: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_control_if.sv
// ============================================================================
// Module   : mips_multicycle_control_if
// Brief    : Opcode/memory handshake in, datapath strobes out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_multicycle_control_if #(
    parameter int OPW = 6
) ();
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           mem_req;
    logic           mem_write;
    logic           iord;
    logic           ir_write;
    logic           pc_write;
    logic           branch;
    logic [1:0]     pc_src;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic           reg_dst;
    logic           mem_to_reg;
    logic           reg_write;
    logic           illegal_op;

    // master = control unit, slave = datapath/memory side
    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               illegal_op
    );
endinterface

`default_nettype wire

// File: rtl/mips_opcode_decode.sv
// ============================================================================
// Module   : mips_opcode_decode
// Brief    : Combinational opcode classifier, one-hot over supported classes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_opcode_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  wire logic [OPW-1:0] i_opcode,
    output op_class_t           o_class
);

    always_comb begin
        o_class            = '0;
        o_class.is_rtype   = (i_opcode == OPW'(c_op_rtype));
        o_class.is_lw      = (i_opcode == OPW'(c_op_lw));
        o_class.is_sw      = (i_opcode == OPW'(c_op_sw));
        o_class.is_beq     = (i_opcode == OPW'(c_op_beq));
        o_class.is_addi    = (i_opcode == OPW'(c_op_addi));
        o_class.is_j       = (i_opcode == OPW'(c_op_j));
        o_class.is_illegal = ~(o_class.is_rtype | o_class.is_lw | o_class.is_sw |
                               o_class.is_beq | o_class.is_addi | o_class.is_j);
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
// ============================================================================
// Module   : mips_multicycle_control
// Brief    : Multicycle MIPS control FSM with memory-ready stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    mips_multicycle_control_if.master  bus
);

    op_class_t w_class;
    state_t    r_state;
    state_t    w_next_state;
    ctrl_t     r_ctrl;
    logic      w_in_fetch;
    logic      w_fetch_done;

    mips_opcode_decode #(
        .OPW (OPW)
    ) u_decode (
        .i_opcode (bus.opcode),
        .o_class  (w_class)
    );

    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_FETCH:    w_next_state = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (w_class.is_lw | w_class.is_sw) w_next_state = ST_MEMADR;
                else if (w_class.is_rtype)          w_next_state = ST_RTEXEC;
                else if (w_class.is_beq)            w_next_state = ST_BEQEXEC;
                else if (w_class.is_addi)           w_next_state = ST_ADDIEXEC;
                else if (w_class.is_j)              w_next_state = ST_JEXEC;
                else                                w_next_state = ST_FETCH;
            end
            ST_MEMADR: begin
                if (w_class.is_lw)      w_next_state = ST_MEMRD;
                else if (w_class.is_sw) w_next_state = ST_MEMWR;
                else                    w_next_state = ST_FETCH;
            end
            ST_MEMRD:    w_next_state = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:    w_next_state = ST_FETCH;
            ST_MEMWR:    w_next_state = bus.mem_ready ? ST_FETCH : ST_MEMWR;
            ST_RTEXEC:   w_next_state = ST_ALUWB;
            ST_ALUWB:    w_next_state = ST_FETCH;
            ST_BEQEXEC:  w_next_state = ST_FETCH;
            ST_ADDIEXEC: w_next_state = ST_ALUWB;
            ST_JEXEC:    w_next_state = ST_FETCH;
            default:     w_next_state = ST_FETCH;
        endcase
    end

    // Strobes are precomputed for the state being entered, so they are glitch-free
    // registers; reg_dst doubles as the RTYPE-vs-ADDI flag for ALUWB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_ctrl  <= ctrl_for_state(ST_FETCH, 1'b0);
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= ctrl_for_state(w_next_state, r_state == ST_RTEXEC);
        end
    end

    assign w_in_fetch   = ~reset & (r_state == ST_FETCH);
    assign w_fetch_done = w_in_fetch & bus.mem_ready;

    // Register reset value is the FETCH set, so reset itself must mask the outputs.
    assign bus.mem_req    = ~reset & r_ctrl.mem_req;
    assign bus.mem_write  = ~reset & r_ctrl.mem_write;
    assign bus.iord       = ~reset & r_ctrl.iord;
    assign bus.ir_write   = w_fetch_done;
    assign bus.pc_write   = (~reset & r_ctrl.pc_write) | w_fetch_done;
    assign bus.branch     = ~reset & r_ctrl.branch;
    assign bus.pc_src     = reset ? 2'b00 : r_ctrl.pc_src;
    assign bus.alu_src_a  = ~reset & r_ctrl.alu_src_a;
    assign bus.alu_src_b  = reset ? 2'b00 : r_ctrl.alu_src_b;
    assign bus.alu_op     = reset ? 2'b00 : r_ctrl.alu_op;
    assign bus.reg_dst    = ~reset & r_ctrl.reg_dst;
    assign bus.mem_to_reg = ~reset & r_ctrl.mem_to_reg;
    assign bus.reg_write  = ~reset & r_ctrl.reg_write;
    assign bus.illegal_op = ~reset & (r_state == ST_DECODE) & w_class.is_illegal;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// ============================================================================
// Module   : tb_mips_multicycle_control
// Brief    : Directed per-cycle vectors against hand-derived output patterns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_control;

    localparam logic [5:0] c_rtype = 6'b000000;
    localparam logic [5:0] c_lw    = 6'b100011;
    localparam logic [5:0] c_sw    = 6'b101011;
    localparam logic [5:0] c_beq   = 6'b000100;
    localparam logic [5:0] c_addi  = 6'b001000;
    localparam logic [5:0] c_j     = 6'b000010;
    localparam logic [5:0] c_bad   = 6'b111111;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mips_multicycle_control_if #(.OPW(6)) bus ();

    mips_multicycle_control #(
        .OPW (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: mem_req mem_write iord ir_write pc_write branch pc_src
    //              alu_src_a alu_src_b alu_op reg_dst mem_to_reg reg_write illegal_op
    function automatic logic [17:0] expv(
        input logic mreq, input logic mw, input logic io, input logic irw,
        input logic pcw, input logic br, input logic [1:0] pcs, input logic sa,
        input logic [1:0] sb, input logic [1:0] op, input logic rd,
        input logic m2r, input logic rw, input logic ill);
        return {mreq, mw, io, irw, pcw, br, pcs, sa, sb, op, rd, m2r, rw, ill};
    endfunction

    function automatic logic [17:0] observed();
        return {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                bus.branch, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal_op};
    endfunction

    function automatic logic [17:0] e_fetch(input logic rdy);
        return expv(1, 0, 0, rdy, rdy, 0, 2'd0, 0, 2'd1, 2'd0, 0, 0, 0, 0);
    endfunction

    function automatic logic [17:0] e_decode(input logic ill);
        return expv(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 2'd0, 0, 0, 0, ill);
    endfunction

    function automatic logic [17:0] e_aluwb(input logic rd);
        return expv(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, rd, 0, 1, 0);
    endfunction

    logic [17:0] e_zero, e_memadr, e_memrd, e_memwb, e_memwr, e_rtexec, e_beq, e_addi, e_jexec;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got[17:0], exp[17:0]);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, then check outputs.
    task automatic cyc(input string tag, input logic rst_v, input logic [5:0] opc,
                       input logic rdy, input logic [17:0] exp);
        @(negedge clk);
        reset         = rst_v;
        bus.opcode    = opc;
        bus.mem_ready = rdy;
        #1;
        check_eq(tag, {14'd0, observed()}, {14'd0, exp});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        e_zero   = '0;
        e_memadr = expv(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd0, 0, 0, 0, 0);
        e_memrd  = expv(1, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        e_memwb  = expv(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1, 1, 0);
        e_memwr  = expv(1, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        e_rtexec = expv(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd2, 0, 0, 0, 0);
        e_beq    = expv(0, 0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 2'd1, 0, 0, 0, 0);
        e_addi   = expv(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd0, 0, 0, 0, 0);
        e_jexec  = expv(0, 0, 0, 0, 1, 0, 2'd2, 0, 2'd0, 2'd0, 0, 0, 0, 0);

        reset         = 1'b1;
        bus.opcode    = c_lw;
        bus.mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) cyc("reset_hold", 1, c_lw, 1, e_zero);

        // LW, no stalls: 5 cycles
        cyc("lw_fetch",  0, c_lw, 1, e_fetch(1));
        cyc("lw_decode", 0, c_lw, 1, e_decode(0));
        cyc("lw_memadr", 0, c_lw, 1, e_memadr);
        cyc("lw_memrd",  0, c_lw, 1, e_memrd);
        cyc("lw_memwb",  0, c_lw, 1, e_memwb);

        // SW with 3 wait cycles; mem_ready toggled where it must be ignored
        cyc("sw_fetch",  0, c_sw, 1, e_fetch(1));
        cyc("sw_decode", 0, c_sw, 0, e_decode(0));
        cyc("sw_memadr", 0, c_sw, 0, e_memadr);
        for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", 0, c_sw, 0, e_memwr);
        cyc("sw_memwr_done", 0, c_sw, 1, e_memwr);

        // FETCH stall then RTYPE
        cyc("fetch_stall", 0, c_rtype, 0, e_fetch(0));
        cyc("rt_fetch",    0, c_rtype, 1, e_fetch(1));
        cyc("rt_decode",   0, c_rtype, 1, e_decode(0));
        cyc("rt_exec",     0, c_rtype, 1, e_rtexec);
        cyc("rt_aluwb",    0, c_rtype, 1, e_aluwb(1));

        cyc("addi_fetch",  0, c_addi, 1, e_fetch(1));
        cyc("addi_decode", 0, c_addi, 1, e_decode(0));
        cyc("addi_exec",   0, c_addi, 1, e_addi);
        cyc("addi_aluwb",  0, c_addi, 1, e_aluwb(0));

        cyc("beq_fetch",  0, c_beq, 1, e_fetch(1));
        cyc("beq_decode", 0, c_beq, 1, e_decode(0));
        cyc("beq_exec",   0, c_beq, 1, e_beq);

        cyc("j_fetch",  0, c_j, 1, e_fetch(1));
        cyc("j_decode", 0, c_j, 1, e_decode(0));
        cyc("j_exec",   0, c_j, 1, e_jexec);

        // Illegal opcode: single-cycle pulse, straight back to FETCH
        cyc("ill_fetch",  0, c_bad, 1, e_fetch(1));
        cyc("ill_decode", 0, c_bad, 1, e_decode(1));
        cyc("ill_refetch", 0, c_lw, 0, e_fetch(0));

        // Reset during a MEMRD wait
        cyc("abort_fetch",  0, c_lw, 1, e_fetch(1));
        cyc("abort_decode", 0, c_lw, 1, e_decode(0));
        cyc("abort_memadr", 0, c_lw, 1, e_memadr);
        cyc("abort_memrd",  0, c_lw, 0, e_memrd);
        cyc("abort_reset",  1, c_lw, 0, e_zero);
        cyc("abort_reset2", 1, c_lw, 1, e_zero);
        cyc("abort_release", 0, c_lw, 1, e_fetch(1));
        cyc("abort_decode2", 0, c_lw, 1, e_decode(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Control FSM for the multicycle 32-bit MIPS datapath.
- Consumes the 6-bit opcode from the instruction register and produces per-cycle datapath strobes and mux selects.
- Stalls on the shared instruction/data memory through a ready handshake.
- Sits between the instruction register/opcode compare logic and the datapath muxes, register file, PC and memory interface.

Parameters:
- OPW, 6, opcode width in bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH immediately.
- opcode  in  6  instr[31:26] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completed the current read/write this cycle.
- mem_req  out  1  memory access requested this cycle.
- mem_write  out  1  request is a write.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out.
- ir_write  out  1  load instruction register.
- pc_write  out  1  unconditional PC load.
- branch  out  1  PC load qualified by ALU zero (beq).
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALU out, 2 = jump target.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B: 0 = register B, 1 = const 4, 2 = sign-extended imm, 3 = imm << 2.
- alu_op  out  2  0 = add, 1 = sub, 2 = use funct field.
- reg_dst  out  1  write register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write data: 0 = ALU out, 1 = memory data.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, ALUWB, BEQEXEC, ADDIEXEC, JEXEC.
- Reset: state = FETCH; while reset is high, all outputs are 0. After release, the first cycle is FETCH.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - ir_write = pc_write = mem_ready (Mealy).
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
  - Next state: LW/SW→MEMADR, RTYPE→RTEXEC, BEQ→BEQEXEC, ADDI→ADDIEXEC, J→JEXEC.
  - Any other opcode: illegal_op=1 for this cycle, next state FETCH. The instruction is dropped; no writes occur.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. LW→MEMRD, SW→MEMWR.
- MEMRD: mem_req=1, iord=1. Wait while mem_ready=0; then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Wait while mem_ready=0; then FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=0, alu_op=2 → ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0. reg_dst=1 if reached from RTEXEC, 0 if from ADDIEXEC (one registered flag) → FETCH.
- BEQEXEC: alu_src_a=1, alu_src_b=0, alu_op=1, branch=1, pc_src=1 → FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=2, alu_op=0 → ALUWB.
- JEXEC: pc_write=1, pc_src=2 → FETCH.
- Any output not listed for a state is 0.
- Instruction latencies with no memory stall: LW 5 cycles, SW/RTYPE/ADDI 4, BEQ/J 3.
- opcode is sampled in DECODE and in MEMADR only. It must be stable from DECODE to the end of the instruction (IR is not written outside FETCH).
- Asserting reset mid-instruction, including during a memory wait, aborts it. No strobe is issued after reset rises.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- State encoding is implementation choice; no state is unreachable-and-stuck. Unknown encodings return to FETCH.

Decomposition:
- Shared package mips_ctrl_pkg:
  - opcode constants.
  - state encoding.
  - alu_op, alu_src_b and pc_src encodings (shared with datapath and ALU control).
- Sub-module mips_opcode_decode: combinational, opcode → one-hot {is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, is_illegal}.

Test Plan:
- Reset held 3 cycles, then released, mem_ready=1 → all outputs 0 during reset; FETCH next cycle with ir_write=1, pc_write=1, alu_src_b=1.
- LW (100011), mem_ready=1 always → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; MEMWB shows reg_write=1, mem_to_reg=1, reg_dst=0.
- SW (101011) with mem_ready low for 3 cycles in MEMWR → mem_req=1 and mem_write=1 held 4 cycles; never reg_write; then FETCH.
- RTYPE then ADDI back-to-back → ALUWB reg_dst=1 for RTYPE, 0 for ADDI; alu_op=2 in RTEXEC; alu_src_b=2 in ADDIEXEC.
- BEQ and J → BEQEXEC branch=1, alu_op=1, pc_src=1; JEXEC pc_write=1, pc_src=2; each takes 3 cycles.
- Opcode 111111 → illegal_op=1 for exactly one cycle in DECODE, no reg_write/mem_write, back to FETCH. Separately: reset asserted mid-MEMRD wait → outputs 0 immediately; FETCH after release.
